fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single FIFO write port between NUM_REQ independent producers.
- Each producer uses a valid/ready handshake.
- The arbiter registers the winning beat onto the FIFO write interface (wr_en/data_in) and throttles on full/almostfull so the FIFO never overflows.
- Sits between producer blocks and the FIFO DUT write side; the read side is untouched.

Parameters:
- FIFO_WIDTH, 16, data width of each requester and of the FIFO data_in.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, max consecutive beats one requester may hold the grant (1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*FIFO_WIDTH  per-requester data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  NUM_REQ  one-hot-or-zero accept; a beat transfers when req_valid[i]&req_ready[i].
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO has exactly one free slot.
- fifo_overflow  in  1  FIFO overflow pulse.
- wr_en  out  1  FIFO write enable (registered).
- data_in  out  FIFO_WIDTH  FIFO write data (registered).
- grant_id  out  $clog2(NUM_REQ)  index of requester owning the current grant (registered).
- err_overflow  out  1  sticky error, set on any fifo_overflow.

Behaviour:
- Reset (rst=1 at clk edge): wr_en=0, data_in=0, grant_id=0, err_overflow=0, req_ready=0 (combinational, forced 0 while rst=1), FSM=ARB, burst_cnt=0, last_grant=NUM_REQ-1. Reset mid-burst abandons the burst; no beat is accepted in the reset cycle.
- Space check: space_ok = !fifo_full && !(fifo_almostfull && wr_en). This accounts for the one beat already registered but not yet written.
- Two-state FSM: ARB and BURST.
- ARB:
  - If space_ok and any req_valid: pick the first valid index searching (last_grant+1) mod NUM_REQ upward with wrap.
  - Assert req_ready[winner] combinationally in that cycle.
  - At the edge: wr_en<=1, data_in<=req_data[winner], grant_id<=winner, last_grant<=winner, burst_cnt<=1.
  - Go to BURST if MAX_BURST>1, else stay in ARB.
  - Otherwise wr_en<=0 and state holds.
- BURST:
  - If req_valid[grant_id] and space_ok and burst_cnt<MAX_BURST: req_ready[grant_id]=1, beat registered as above, burst_cnt++.
  - If burst_cnt reaches MAX_BURST on that beat, go to ARB.
  - If req_valid[grant_id]=0: go to ARB with no beat that cycle (wr_en<=0). The next arbitration starts after grant_id.
  - If !space_ok: stall in BURST with wr_en<=0 and the grant kept; burst_cnt is not cleared.
- Latency: accepted beat appears on wr_en/data_in exactly 1 cycle after the handshake. Ordering per requester is preserved.
- At most one req_ready bit is high per cycle. req_ready never depends on req_valid of non-granted requesters in BURST.
- Requesters holding valid with stable data are never starved: worst-case wait is (NUM_REQ-1)*(MAX_BURST) beats plus stall cycles.
- err_overflow: set the cycle after fifo_overflow=1; cleared only by rst.
- The FIFO read side may drain simultaneously. A full deassertion is used the same cycle it is observed.

Test Plan:
- Single requester: rst 2 cycles, req_valid=4'b0001, data 0x1000..0x1009 on 10 consecutive beats, FIFO empty → 10 accepts back-to-back. wr_en high cycles 1..10 after first handshake. data_in in order, grant_id=0 throughout (re-arbitration every 4 beats re-selects 0).
- All four valid, continuous, no backpressure, MAX_BURST=4 → grant_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; req_ready always one-hot.
- Backpressure: hold fifo_almostfull=1 while wr_en=1 → req_ready=0 that cycle. Then fifo_full=1 for 5 cycles → no wr_en, grant_id held, burst resumes with burst_cnt unchanged after full drops.
- Early burst release: requester 2 drops valid after 2 beats while 3 valid → one idle cycle, then grant_id=3. The next grant after 3 wraps to 0.
- Reset mid-burst: assert rst in BURST at burst_cnt=2 → next cycle wr_en=0, grant_id=0, req_ready=0. After release with all valid, first grant goes to requester 0.
- Force fifo_overflow=1 one cycle → err_overflow=1 from next cycle, stays 1 until rst.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: several valid/ready producers share one FIFO
// write port. The winning beat is registered onto wr_en/data_in. A grant may
// hold the port for up to MAX_BURST consecutive beats. Writes are throttled on
// full/almostfull so the FIFO cannot overflow.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_overflow,
    output logic                          wr_en,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          err_overflow
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic {
        ARB,
        BURST
    } state_t;

    state_t          state_q;
    state_t          state_nx;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   burst_nx;
    logic [GW-1:0]   last_grant;
    logic            space_ok;
    logic            accept;
    logic [GW-1:0]   sel;
    logic            arb_found;
    logic [GW-1:0]   arb_winner;
    logic            found_hi;
    logic [GW-1:0]   win_hi;
    logic [GW-1:0]   win_lo;

    // A beat already sitting on wr_en takes the last free slot when almostfull.
    assign space_ok = !fifo_full && !(fifo_almostfull && wr_en);

    // Round-robin search: lowest valid index above last_grant, otherwise wrap
    // to the lowest valid index overall.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        found_hi = 1'b0;
        arb_found = 1'b0;
        win_hi = '0;
        win_lo = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (GW'(i) > last_grant) begin
                    win_hi = GW'(i);
                    found_hi = 1'b1;
                end
                win_lo = GW'(i);
                arb_found = 1'b1;
            end
        end
        arb_winner = found_hi ? win_hi : win_lo;
    end

    // Next-state, beat acceptance and the one-hot ready for the selected requester.
    always_comb begin
        state_nx = state_q;
        burst_nx = burst_cnt;
        accept = 1'b0;
        sel = grant_id;
        req_ready = '0;
        case (state_q)
            ARB: begin
                if (space_ok && arb_found) begin
                    accept = 1'b1;
                    sel = arb_winner;
                    burst_nx = CW'(1);
                    if (MAX_BURST > 1) begin
                        state_nx = BURST;
                    end
                end
            end
            BURST: begin
                if (!req_valid[grant_id]) begin
                    // Owner went idle: release the grant, no beat this cycle.
                    state_nx = ARB;
                end else if (burst_cnt >= MAX_CNT) begin
                    state_nx = ARB;
                end else if (space_ok) begin
                    accept = 1'b1;
                    burst_nx = burst_cnt + CW'(1);
                    if (burst_nx == MAX_CNT) begin
                        state_nx = ARB;
                    end
                end
                // !space_ok: stall with grant and burst_cnt kept.
            end
            default: state_nx = ARB;
        endcase
        // Nothing is handed over while reset is held.
        if (accept && !rst) begin
            req_ready[sel] = 1'b1;
        end
    end

    // FSM state register, burst length and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ARB;
            burst_cnt <= '0;
            last_grant <= GW'(NUM_REQ - 1);
        end else begin
            state_q <= state_nx;
            burst_cnt <= burst_nx;
            if (accept && state_q == ARB) begin
                last_grant <= sel;
            end
        end
    end

    // Registered FIFO write interface: an accepted beat appears one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en <= 1'b0;
            data_in <= '0;
            grant_id <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                data_in <= req_data[sel*FIFO_WIDTH +: FIFO_WIDTH];
                grant_id <= sel;
            end
        end
    end

    // Sticky overflow error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow <= 1'b0;
        end else if (fifo_overflow) begin
            err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (FIFO_WIDTH=16, NUM_REQ=4, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; registered outputs and the
// combinational ready are sampled away from the edge.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] dat [4];
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_almostfull;
    logic        fifo_overflow;
    logic        wr_en;
    logic [15:0] data_in;
    logic [1:0]  grant_id;
    logic        err_overflow;

    int tests = 0;
    int fails = 0;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .FIFO_WIDTH(16),
        .NUM_REQ(4),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_almostfull(fifo_almostfull),
        .fifo_overflow(fifo_overflow),
        .wr_en(wr_en),
        .data_in(data_in),
        .grant_id(grant_id),
        .err_overflow(err_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational ready for the inputs just applied, then clock the
    // beat and check the registered write it produces.
    task automatic beat(input string tag, input logic [3:0] rdy, input logic [1:0] gid,
                        input logic [15:0] d);
        #1 check({tag, "_ready"}, req_ready, rdy);
        step();
        check({tag, "_wr_en"}, wr_en, 1);
        check({tag, "_grant"}, grant_id, gid);
        check({tag, "_data"}, data_in, d);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) dat[i] = 16'h0;
        fifo_full = 1'b0;
        fifo_almostfull = 1'b0;
        fifo_overflow = 1'b0;

        // Reset state; ready forced low even with every requester valid.
        step();
        step();
        #1 check("rst_ready", req_ready, 4'b0000);
        check("rst_wr_en", wr_en, 0);
        check("rst_data", data_in, 0);
        check("rst_grant", grant_id, 0);
        check("rst_err", err_overflow, 0);

        // Single requester: 10 back-to-back beats, re-arbitration reselects 0.
        rst = 1'b0;
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            dat[0] = 16'h1000 + 16'(k);
            beat("single", 4'b0001, 2'd0, 16'h1000 + 16'(k));
        end
        req_valid = 4'b0000;
        #1 check("single_idle_ready", req_ready, 4'b0000);
        step();
        check("single_idle_wr_en", wr_en, 0);

        // All four valid: bursts of 4 rotating 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 16'h2000 | (16'(i) << 8);
        req_valid = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            beat("rr", 4'b0001 << ((k / 4) % 4), 2'((k / 4) % 4),
                 16'h2000 | (16'((k / 4) % 4) << 8));
        end

        // Backpressure: almostfull with a beat on wr_en blocks this cycle.
        fifo_almostfull = 1'b1;
        #1 check("afull_ready", req_ready, 4'b0000);
        step();
        check("afull_wr_en", wr_en, 0);
        check("afull_grant", grant_id, 0);
        fifo_almostfull = 1'b0;
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 check("full_ready", req_ready, 4'b0000);
            step();
            check("full_wr_en", wr_en, 0);
            check("full_grant", grant_id, 0);
        end
        // Burst resumes at count 1: three more beats of 0, then requester 1.
        fifo_full = 1'b0;
        for (int k = 0; k < 3; k++) beat("resume", 4'b0001, 2'd0, 16'h2000);
        beat("resume_next", 4'b0010, 2'd1, 16'h2100);
        req_valid = 4'b0000;
        #1 check("drop1_ready", req_ready, 4'b0000);
        step();
        check("drop1_wr_en", wr_en, 0);

        // Early release: 2 drops after two beats, idle cycle, then 3, then wrap to 0.
        dat[0] = 16'h4000;
        dat[2] = 16'h4200;
        dat[3] = 16'h4300;
        req_valid = 4'b1100;
        beat("early2", 4'b0100, 2'd2, 16'h4200);
        beat("early2", 4'b0100, 2'd2, 16'h4200);
        req_valid = 4'b1000;
        #1 check("early_gap_ready", req_ready, 4'b0000);
        step();
        check("early_gap_wr_en", wr_en, 0);
        beat("early3", 4'b1000, 2'd3, 16'h4300);
        req_valid = 4'b0001;
        #1 check("early3_drop_ready", req_ready, 4'b0000);
        step();
        check("early3_drop_wr_en", wr_en, 0);
        req_valid = 4'b1001;
        beat("wrap0", 4'b0001, 2'd0, 16'h4000);

        // Reset mid-burst on requester 2 at burst_cnt=2.
        for (int i = 0; i < 4; i++) dat[i] = 16'h5000 | (16'(i) << 8);
        req_valid = 4'b0100;
        #1 check("pre_mid_ready", req_ready, 4'b0000);
        step();
        beat("mid2", 4'b0100, 2'd2, 16'h5200);
        beat("mid2", 4'b0100, 2'd2, 16'h5200);
        rst = 1'b1;
        req_valid = 4'b1111;
        #1 check("mid_rst_ready", req_ready, 4'b0000);
        step();
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_grant", grant_id, 0);
        check("mid_rst_data", data_in, 0);
        rst = 1'b0;
        beat("post_rst", 4'b0001, 2'd0, 16'h5000);

        // Sticky overflow error.
        req_valid = 4'b0000;
        check("err_before", err_overflow, 0);
        fifo_overflow = 1'b1;
        step();
        fifo_overflow = 1'b0;
        check("err_set", err_overflow, 1);
        step();
        step();
        step();
        check("err_sticky", err_overflow, 1);
        rst = 1'b1;
        step();
        check("err_cleared", err_overflow, 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
